// File: rtl/control_unit.sv
// Moore control unit for a simple multi-cycle datapath.
// Sequences fetch, decode, ALU and mul/div execute steps, with halt support.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic [4:0]  opcode,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_DEC,
        S_A3,
        S_A4,
        S_A5,
        S_M3,
        S_M4,
        S_M5,
        S_M6,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state_q;
    state_t     state_d;
    state_t     boundary_next;
    logic [4:0] ir_op;
    logic       is_alu;
    logic       is_muldiv;
    logic       is_halt;
    logic       unused_ir;

    assign ir_op     = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign is_alu    = (ir_op >= OP_ADD) && (ir_op <= OP_ROL);
    assign is_muldiv = (ir_op == OP_MUL) || (ir_op == OP_DIV);
    assign is_halt   = (ir_op == OP_HALT);

    // Stop is only honoured where one instruction ends and the next would begin.
    assign boundary_next = Stop ? S_HALT : S_T0;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        opcode   = 5'b00000;
        Run      = 1'b1;

        unique case (state_q)
            S_RST: begin
                Run     = 1'b0;
                state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                PCin    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                if (is_alu) begin
                    state_d = S_A3;
                end else if (is_muldiv) begin
                    state_d = S_M3;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = boundary_next;
                end
            end
            S_A3: begin
                Grb     = 1'b1;
                Rout    = 1'b1;
                Yin     = 1'b1;
                state_d = S_A4;
            end
            S_A4: begin
                Grc     = 1'b1;
                Rout    = 1'b1;
                Zin     = 1'b1;
                opcode  = ir_op;
                state_d = S_A5;
            end
            S_A5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                state_d = boundary_next;
            end
            // mul/div takes ra as first operand and writes HI/LO, not a register
            S_M3: begin
                Gra     = 1'b1;
                Rout    = 1'b1;
                Yin     = 1'b1;
                state_d = S_M4;
            end
            S_M4: begin
                Grb     = 1'b1;
                Rout    = 1'b1;
                Zin     = 1'b1;
                opcode  = ir_op;
                state_d = S_M5;
            end
            S_M5: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
                state_d = S_M6;
            end
            S_M6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = boundary_next;
            end
            S_HALT: begin
                Run     = 1'b0;
                state_d = S_HALT;
            end
            default: begin
                Run     = 1'b0;
                state_d = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: cycle model of instruction steps plus directed
// literal checks on latency, opcode, halt and asynchronous clear.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = 32'h0;

    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, Yin, Zin, Zlowout, Zhighout;
    logic LOin, HIin, Run;
    logic [4:0] opcode;

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .LOin(LOin), .HIin(HIin), .opcode(opcode), .Run(Run)
    );

    always #5 Clock = ~Clock;

    logic [24:0] outv;
    assign outv = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                   Gra, Grb, Grc, Rin, Rout, Yin, Zin, Zlowout, Zhighout,
                   LOin, HIin, opcode, Run};

    // Model: position within the current instruction and its class.
    // Class 0 = nop/illegal, 1 = ALU, 2 = mul/div, 3 = halt.
    bit m_rst  = 1'b1;
    bit m_halt = 1'b0;
    int m_step = 0;
    int m_cls  = 0;

    function automatic int classify(input logic [4:0] o);
        if (o >= 5'd3 && o <= 5'd11) return 1;
        if (o == 5'd15 || o == 5'd16) return 2;
        if (o == 5'd27) return 3;
        return 0;
    endfunction

    function automatic int ilen(input int c);
        if (c == 1) return 7;
        if (c == 2) return 8;
        return 4;
    endfunction

    always @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            m_rst  = 1'b1;
            m_halt = 1'b0;
            m_step = 0;
        end else if (m_rst) begin
            m_rst  = 1'b0;
            m_step = 0;
        end else if (!m_halt) begin
            if (m_step == 3) m_cls = classify(IR[31:27]);
            if (m_step == 3 && m_cls == 3) begin
                m_halt = 1'b1;
            end else if (m_step >= 3 && m_step + 1 == ilen(m_cls)) begin
                if (Stop) m_halt = 1'b1;
                m_step = 0;
            end else begin
                m_step = m_step + 1;
            end
        end
    end

    function automatic logic [24:0] expv();
        logic pco, mar, inc, pci, rd, mdi, mdo, iri;
        logic ga, gb, gc, ri, ro, yi, zi, zl, zh, lo, hi;
        logic [4:0] o;
        {pco, mar, inc, pci, rd, mdi, mdo, iri} = 8'h00;
        {ga, gb, gc, ri, ro, yi, zi, zl, zh, lo, hi} = 11'h000;
        o = 5'd0;
        if (m_rst || m_halt) return 25'd0;
        case (m_step)
            0: {pco, mar, inc, pci} = 4'hF;
            1: {rd, mdi} = 2'b11;
            2: {mdo, iri} = 2'b11;
            4: begin
                ro = 1'b1;
                yi = 1'b1;
                if (m_cls == 1) gb = 1'b1;
                else ga = 1'b1;
            end
            5: begin
                ro = 1'b1;
                zi = 1'b1;
                o  = IR[31:27];
                if (m_cls == 1) gc = 1'b1;
                else gb = 1'b1;
            end
            6: begin
                zl = 1'b1;
                if (m_cls == 1) {ga, ri} = 2'b11;
                else lo = 1'b1;
            end
            7: {zh, hi} = 2'b11;
            default: ;
        endcase
        return {pco, mar, inc, pci, rd, mdi, mdo, iri,
                ga, gb, gc, ri, ro, yi, zi, zl, zh, lo, hi, o, 1'b1};
    endfunction

    always @(posedge Clock) begin
        logic [24:0] e;
        #1;
        e = expv();
        checks++;
        if (outv !== e) begin
            failures++;
            $display("FAIL model t=%0t got=%b exp=%b", $time, outv, e);
        end
        checks++;
        if ($countones({PCout, MDRout, Rout, Zlowout, Zhighout}) > 1) begin
            failures++;
            $display("FAIL bus_driver t=%0t got=%b exp=at-most-one",
                     $time, {PCout, MDRout, Rout, Zlowout, Zhighout});
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic wait_mask(input logic [24:0] mask, input string nm);
        int n;
        n = 0;
        while ((outv & mask) != mask && n < 30) begin
            @(posedge Clock);
            #1;
            n++;
        end
        if ((outv & mask) != mask) chk({nm, "_timeout"}, outv, mask);
    endtask

    task automatic instr(input logic [31:0] ir, input int len,
                         input logic [4:0] op_exp, input string nm);
        int n;
        logic [4:0] seen;
        IR   = ir;
        seen = 5'd0;
        n    = 0;
        while (!PCout && n < 20) begin
            @(posedge Clock);
            #1;
            n++;
        end
        chk({nm, "_t0"}, {31'd0, PCout}, 32'd1);
        n = 0;
        do begin
            @(posedge Clock);
            #1;
            n++;
            if (opcode != 5'd0) seen = opcode;
        end while (!PCout && n < 20);
        chk({nm, "_len"}, n, len);
        chk({nm, "_op"}, {27'd0, seen}, {27'd0, op_exp});
    endtask

    localparam logic [24:0] M_A3 = 25'h0009800;
    localparam logic [24:0] M_A4 = 25'h0005400;
    localparam logic [24:0] M_M4 = 25'h0009400;

    initial begin
        int n;
        #1 Clear = 1'b0;
        #1 chk("reset_out", {7'd0, outv}, 32'd0);
        @(negedge Clock);
        Clear = 1'b1;

        instr(32'h28918000, 7, 5'b00101, "and");
        instr(32'h50000000, 7, 5'b01010, "ror");
        instr(32'h78000000, 8, 5'b01111, "mul");
        instr(32'h80000000, 8, 5'b10000, "div");
        instr(32'hD0000000, 4, 5'b00000, "nop");
        instr(32'hF8000000, 4, 5'b00000, "illegal");

        IR = 32'h18000000;
        wait_mask(M_A3, "a3");
        @(negedge Clock);
        Stop = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        wait_mask(25'h1000000, "pulse_t0");
        chk("pulse_run", {31'd0, Run}, 32'd1);

        wait_mask(M_A4, "a4");
        @(negedge Clock);
        Stop = 1'b1;
        @(posedge Clock);
        #1 chk("stop_a5", {31'd0, Zlowout & Gra}, 32'd1);
        @(posedge Clock);
        #1 chk("stop_halt", {31'd0, Run}, 32'd0);
        repeat (10) @(posedge Clock);
        #1 chk("halt_hold", {7'd0, outv}, 32'd0);
        @(negedge Clock);
        Clear = 1'b0;
        Stop  = 1'b0;
        #1 chk("clr_halt", {7'd0, outv}, 32'd0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock);
        #1 chk("clr_halt_t0", {30'd0, PCout, Run}, 32'd3);

        IR = 32'h78000000;
        wait_mask(M_M4, "m4");
        @(negedge Clock);
        #2 Clear = 1'b0;
        #1 chk("clr_m4", {7'd0, outv}, 32'd0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock);
        #1 chk("clr_m4_t0", {30'd0, PCout, Run}, 32'd3);

        IR = 32'hD8000000;
        n  = 0;
        while (Run && n < 20) begin
            @(posedge Clock);
            #1;
            n++;
        end
        chk("halt_op_lat", n, 4);
        repeat (5) @(posedge Clock);
        #1 chk("halt_op_hold", {31'd0, Run}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
